// File: rtl/iserdes_align_ctrl.sv
// Word-alignment controller for one ISERDESE2 lane, clocked in the CLKDIV domain.
// The controller issues spaced BITSLIP pulses until the training word has been seen
// on MATCH_COUNT consecutive valid words. Retries are bounded, and retrain restarts it.
// Optional statistics outputs are enabled by defining ISERDES_ALIGN_STATS_EN.
module iserdes_align_ctrl #(
   parameter int unsigned DATA_WIDTH    = 8,
   parameter logic [7:0]  TRAIN_PATTERN = 8'h0A,
   parameter int unsigned MATCH_COUNT   = 16,
   parameter int unsigned SETTLE_CYCLES = 3,
   parameter int unsigned MAX_SLIPS     = 8,
   parameter int unsigned MAX_SWEEPS    = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  locked_in,
   input  logic                  retrain,
   input  logic [DATA_WIDTH-1:0] q,
   input  logic                  q_valid,
   output logic                  bitslip,
   output logic                  aligned,
   output logic                  align_fail,
   output logic [3:0]            slip_count,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  data_valid,
   output logic [2:0]            state
`ifdef ISERDES_ALIGN_STATS_EN
   ,
   output logic [7:0]            relock_cnt,
   output logic [15:0]           total_slips
`endif
);

   localparam int unsigned SETTLE_W = $clog2(SETTLE_CYCLES + 1);

   localparam logic [DATA_WIDTH-1:0] PATTERN     = TRAIN_PATTERN[DATA_WIDTH-1:0];
   localparam logic [DATA_WIDTH-1:0] ALL_ONES    = '1;
   localparam logic [7:0]            MATCH_LIM   = 8'(MATCH_COUNT);
   localparam logic [3:0]            SLIP_LIM    = 4'(MAX_SLIPS);
   localparam logic [3:0]            SWEEP_LIM   = 4'(MAX_SWEEPS);
   localparam logic [SETTLE_W-1:0]   SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SAMPLE = 3'd1,
      ST_SLIP   = 3'd2,
      ST_SETTLE = 3'd3,
      ST_VERIFY = 3'd4,
      ST_LOCKED = 3'd5,
      ST_FAIL   = 3'd6
   } state_e;

   state_e              cur_state;
   logic [7:0]          match_cnt;
   logic [3:0]          sweep_cnt;
   logic [SETTLE_W-1:0] settle_cnt;
   logic                pat_hit;
   logic                idle_word;

   assign state     = cur_state;
   assign pat_hit   = (q == PATTERN);
   assign idle_word = (q == ALL_ONES);

   // Alignment FSM with registered outputs; enable/lock loss and retrain take priority
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cur_state  <= ST_IDLE;
         bitslip    <= 1'b0;
         aligned    <= 1'b0;
         align_fail <= 1'b0;
         slip_count <= 4'd0;
         match_cnt  <= 8'd0;
         sweep_cnt  <= 4'd0;
         settle_cnt <= '0;
         data_out   <= '0;
         data_valid <= 1'b0;
      end else begin
         // bitslip is a single-cycle pulse unless re-armed below
         bitslip <= 1'b0;
         if (!en || !locked_in) begin
            cur_state  <= ST_IDLE;
            aligned    <= 1'b0;
            align_fail <= 1'b0;
            slip_count <= 4'd0;
            match_cnt  <= 8'd0;
            sweep_cnt  <= 4'd0;
            settle_cnt <= '0;
            data_valid <= 1'b0;
         end else if (retrain) begin
            cur_state  <= ST_SAMPLE;
            aligned    <= 1'b0;
            align_fail <= 1'b0;
            slip_count <= 4'd0;
            match_cnt  <= 8'd0;
            sweep_cnt  <= 4'd0;
            settle_cnt <= '0;
            data_valid <= 1'b0;
         end else begin
            case (cur_state)
               ST_IDLE: cur_state <= ST_SAMPLE;
               ST_SAMPLE: begin
                  if (q_valid) begin
                     if (pat_hit) begin
                        match_cnt <= 8'd1;
                        cur_state <= (MATCH_LIM == 8'd1) ? ST_LOCKED : ST_VERIFY;
                     end else if (!idle_word) begin
                        if (slip_count < SLIP_LIM) begin
                           bitslip    <= 1'b1;
                           slip_count <= slip_count + 4'd1;
                           cur_state  <= ST_SLIP;
                        end else begin
                           // sweep exhausted without a match: start a new sweep or give up
                           slip_count <= 4'd0;
                           if ((sweep_cnt + 4'd1) >= SWEEP_LIM) begin
                              sweep_cnt  <= SWEEP_LIM;
                              align_fail <= 1'b1;
                              cur_state  <= ST_FAIL;
                           end else begin
                              sweep_cnt <= sweep_cnt + 4'd1;
                           end
                        end
                     end
                  end
               end
               ST_SLIP: begin
                  settle_cnt <= '0;
                  cur_state  <= ST_SETTLE;
               end
               ST_SETTLE: begin
                  if (settle_cnt == SETTLE_LAST) begin
                     cur_state <= ST_SAMPLE;
                  end else begin
                     settle_cnt <= settle_cnt + SETTLE_W'(1);
                  end
               end
               ST_VERIFY: begin
                  if (q_valid) begin
                     if (!pat_hit) begin
                        match_cnt <= 8'd0;
                        cur_state <= ST_SAMPLE;
                     end else if ((match_cnt + 8'd1) >= MATCH_LIM) begin
                        match_cnt <= MATCH_LIM;
                        cur_state <= ST_LOCKED;
                     end else begin
                        match_cnt <= match_cnt + 8'd1;
                     end
                  end
               end
               ST_LOCKED: begin
                  aligned    <= 1'b1;
                  data_out   <= q;
                  data_valid <= q_valid;
               end
               ST_FAIL: align_fail <= 1'b1;
               default: cur_state <= ST_IDLE;
            endcase
         end
      end
   end

`ifdef ISERDES_ALIGN_STATS_EN
   logic was_locked;
   logic locked_once;

   // Saturating relock and bitslip statistics, cleared only by reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         was_locked  <= 1'b0;
         locked_once <= 1'b0;
         relock_cnt  <= 8'd0;
         total_slips <= 16'd0;
      end else begin
         was_locked <= (cur_state == ST_LOCKED);
         if ((cur_state == ST_LOCKED) && !was_locked) begin
            locked_once <= 1'b1;
            if (locked_once && (relock_cnt != 8'hFF)) begin
               relock_cnt <= relock_cnt + 8'd1;
            end
         end
         if (bitslip && (total_slips != 16'hFFFF)) begin
            total_slips <= total_slips + 16'd1;
         end
      end
   end
`endif

endmodule

// File: doc/iserdes_align_ctrl.md
Name: iserdes_align_ctrl

Overview:
Word-alignment controller for one ISERDESE2 lane in the chip-to-chip link. It runs in the divided-clock domain and watches the deserialised word during training. It issues single-cycle BITSLIP pulses with settle gaps until the training pattern is seen on MATCH_COUNT consecutive valid words, then declares the lane aligned and passes data through. It replaces free-running bitslip logic and adds bounded retry, failure reporting and on-demand retraining.

Parameters:
DATA_WIDTH, 8, deserialised word width (2..8).
TRAIN_PATTERN, 8'h0A, training word; compared on DATA_WIDTH LSBs.
MATCH_COUNT, 16, consecutive matching valid words required to lock (1..255).
SETTLE_CYCLES, 3, clk cycles to wait after a bitslip pulse before sampling (>=2).
MAX_SLIPS, 8, bitslips without a match before a sweep fails (1..15).
MAX_SWEEPS, 4, failed sweeps before entering FAIL (1..15).

Ports:
clk  in  1  divided clock (ISERDES CLKDIV).
rst  in  1  asynchronous active-low reset.
en  in  1  enables training; low forces IDLE.
locked_in  in  1  source clock/MMCM locked, synchronous to clk.
retrain  in  1  one-cycle pulse; forces realignment from any state.
q  in  DATA_WIDTH  ISERDES parallel output.
q_valid  in  1  word valid (ce1&ce2 in 2-CE mode).
bitslip  out  1  to ISERDES BITSLIP; one-cycle pulse.
aligned  out  1  high only in LOCKED.
align_fail  out  1  high only in FAIL.
slip_count  out  4  bitslips issued in current sweep.
data_out  out  DATA_WIDTH  registered q, valid only when aligned.
data_valid  out  1  registered q_valid & aligned.
state  out  3  encoded FSM state for debug.

Behaviour:
- Reset (rst=0): state=IDLE; bitslip=0, aligned=0, align_fail=0, slip_count=0, data_out=0, data_valid=0; match and sweep counters cleared.
- State encoding: IDLE=0, SAMPLE=1, SLIP=2, SETTLE=3, VERIFY=4, LOCKED=5, FAIL=6.
- IDLE: stays while en=0 or locked_in=0; otherwise next cycle -> SAMPLE.
- SAMPLE: waits for q_valid=1. If q==TRAIN_PATTERN -> VERIFY with match_cnt=1. If q==all-ones (line idle), stays in SAMPLE and no slip is issued. Otherwise:
  - if slip_count<MAX_SLIPS -> SLIP;
  - else sweep_cnt+1, slip_count=0; if sweep_cnt reaches MAX_SWEEPS -> FAIL, else stays in SAMPLE.
- SLIP: bitslip=1 for exactly this one cycle; slip_count+1; -> SETTLE.
- SETTLE: counts SETTLE_CYCLES cycles with bitslip=0, then -> SAMPLE. Words arriving during SETTLE are ignored.
- VERIFY: on each q_valid word, a match increments match_cnt; a mismatch clears match_cnt and -> SAMPLE. When match_cnt reaches MATCH_COUNT -> LOCKED, and aligned goes high the following cycle. Cycles with q_valid=0 hold match_cnt.
- LOCKED: aligned=1; data_out<=q and data_valid<=q_valid every cycle, one cycle latency. slip_count holds its final value. The FSM does not compare data in this state.
- FAIL: align_fail=1. Stays until retrain, en=0, or locked_in=0.
- Global overrides, checked before state logic in this priority:
  1. en=0 or locked_in=0 -> IDLE; all counters, aligned and data_valid cleared; a bitslip pulse in progress is not extended.
  2. retrain=1 -> SAMPLE; counters cleared; aligned drops the next cycle.
- Invariants:
  - bitslip is never high on two consecutive cycles.
  - Minimum spacing between bitslip pulses is SETTLE_CYCLES+2 cycles.
  - Counters saturate and never wrap.
  - At most MAX_SLIPS*MAX_SWEEPS pulses are issued before FAIL.

Optional Feature:
ISERDES_ALIGN_STATS_EN: adds outputs relock_cnt[7:0] and total_slips[15:0], both saturating and cleared only by rst. relock_cnt increments on each LOCKED entry after the first. total_slips increments on every bitslip pulse. Without the macro these ports and registers do not exist and behaviour is otherwise identical.

Test Plan:
1. q=8'h0A continuous, q_valid=1, en=1, locked_in=1 -> no bitslip pulses; aligned rises 1+16+1 cycles after leaving IDLE; slip_count=0.
2. Lane model rotated by 3 bits (q=8'h41), each bitslip rotates one bit -> exactly 3 bitslip pulses spaced >=5 cycles apart; then locked with slip_count=3.
3. q=8'hFF for 100 cycles, then 8'h0A -> no bitslip during the all-ones period; lock follows 16 matches.
4. Random non-pattern q forever, MAX_SLIPS=8, MAX_SWEEPS=4 -> exactly 32 bitslip pulses, then align_fail=1, state=6; a retrain pulse returns state to 1.
5. In VERIFY, a mismatch at match 10 -> match counter clears and state returns to SAMPLE. Separately, in LOCKED, drop locked_in for 1 cycle -> aligned=0 and state=IDLE next cycle; relock completes after 16 matches.
6. Assert rst mid-SETTLE while bitslip was just pulsed -> all outputs 0 immediately (asynchronous); with ISERDES_ALIGN_STATS_EN defined, relock_cnt=0 and total_slips=0.
